mem_copy_host: RTL and testbench

MEM_COPY_HOST -- requirements
Module: mem_copy_host

---
 rtl/mem_copy_host.sv | 200 ++++++++++++++++++++
 tb/tb_mem_copy_host.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_host.sv
// Word-by-word memory copy engine acting as a TL-UL host: Get a word, PutFullData it, repeat.
// Define MEM_COPY_HOST_CAP_EN to forward the read response capability tag onto the write request.
package tlul_pkg;
    typedef enum logic [2:0] {PutFullData = 3'h0, PutPartialData = 3'h1, Get = 3'h4} tl_a_op_e;
    typedef enum logic [2:0] {AccessAck = 3'h0, AccessAckData = 3'h1} tl_d_op_e;

    typedef struct packed {
        logic [3:0] cap_tag;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [3:0] cap_tag;
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        tl_d_user_t  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    // Integrity code: payload bit i lands in code bit (63-i) mod 7.
    function automatic logic [6:0] intg7(input logic [63:0] v);
        logic [6:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            r = {r[5:0], r[6] ^ v[i]};
        end
        return r;
    endfunction
endpackage

module mem_copy_host #(
    parameter int LenWidth = 16,
    parameter int SourceId = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [31:0]           src_addr_i,
    input  logic [31:0]           dst_addr_i,
    input  logic [LenWidth-1:0]   len_words_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output tlul_pkg::tl_h2d_t     tl_o,
    input  tlul_pkg::tl_d2h_t     tl_i
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_RSP, WR_REQ, WR_RSP, DONE} state_e;

    state_e              state_reg, state_next;
    logic [31:0]         src_reg, src_next;
    logic [31:0]         dst_reg, dst_next;
    logic [31:0]         data_reg, data_next;
    logic [LenWidth-1:0] cnt_reg, cnt_next;
    logic                err_reg, err_next;
    logic [3:0]          wr_cap;

`ifdef MEM_COPY_HOST_CAP_EN
    logic [3:0] cap_reg, cap_next;
    assign wr_cap = cap_reg;
`else
    assign wr_cap = 4'd0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            src_reg   <= '0;
            dst_reg   <= '0;
            data_reg  <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
`ifdef MEM_COPY_HOST_CAP_EN
            cap_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            src_reg   <= src_next;
            dst_reg   <= dst_next;
            data_reg  <= data_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
`ifdef MEM_COPY_HOST_CAP_EN
            cap_reg   <= cap_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        src_next   = src_reg;
        dst_next   = dst_reg;
        data_next  = data_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
`ifdef MEM_COPY_HOST_CAP_EN
        cap_next   = cap_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    src_next   = {src_addr_i[31:2], 2'b00};
                    dst_next   = {dst_addr_i[31:2], 2'b00};
                    cnt_next   = len_words_i;
                    err_next   = 1'b0;
                    state_next = (len_words_i == '0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: if (tl_i.a_ready) state_next = RD_RSP;
            RD_RSP: begin
                if (tl_i.d_valid) begin
                    if (tl_i.d_error) begin
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        data_next  = tl_i.d_data;
`ifdef MEM_COPY_HOST_CAP_EN
                        cap_next   = tl_i.d_user.cap_tag;
`endif
                        state_next = WR_REQ;
                    end
                end
            end
            WR_REQ: if (tl_i.a_ready) state_next = WR_RSP;
            WR_RSP: begin
                if (tl_i.d_valid) begin
                    if (tl_i.d_error) begin
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        src_next   = src_reg + 32'd4;
                        dst_next   = dst_reg + 32'd4;
                        cnt_next   = cnt_reg - LenWidth'(1);
                        state_next = (cnt_reg == LenWidth'(1)) ? DONE : RD_REQ;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A-channel fields come only from registers, so they hold steady through back-pressure.
    logic                  is_wr;
    logic [31:0]           a_addr;
    logic [31:0]           a_data;
    tlul_pkg::tl_a_op_e    a_op;

    assign is_wr  = (state_reg == WR_REQ);
    assign a_addr = is_wr ? dst_reg : src_reg;
    assign a_data = is_wr ? data_reg : 32'd0;
    assign a_op   = is_wr ? tlul_pkg::PutFullData : tlul_pkg::Get;

    always_comb begin
        tl_o                  = '0;
        tl_o.a_valid          = (state_reg == RD_REQ) || is_wr;
        tl_o.a_opcode         = a_op;
        tl_o.a_size           = 2'd2;
        tl_o.a_source         = 8'(SourceId);
        tl_o.a_address        = a_addr;
        tl_o.a_mask           = 4'hF;
        tl_o.a_data           = a_data;
        tl_o.a_user.cap_tag   = is_wr ? wr_cap : 4'd0;
        tl_o.a_user.cmd_intg  = tlul_pkg::intg7({23'd0, a_op, 2'd2, 4'hF, a_addr});
        tl_o.a_user.data_intg = tlul_pkg::intg7({32'd0, a_data});
        tl_o.d_ready          = 1'b1;
    end

    assign busy_o = (state_reg != IDLE);
    assign done_o = (state_reg == DONE);
    assign err_o  = err_reg;

    logic unused_inputs;
    assign unused_inputs = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                             tl_i.d_sink, tl_i.d_user, src_addr_i[1:0], dst_addr_i[1:0]};
endmodule

// File: tb/tb_mem_copy_host.sv
// Directed bench for mem_copy_host: a cycle-stepped TL-UL device model feeds a request scoreboard.
module tb_mem_copy_host;
    import tlul_pkg::*;

    localparam int SRC_ID = 5;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] src_addr_i;
    logic [31:0] dst_addr_i;
    logic [15:0] len_words_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    tl_h2d_t     tl_o;
    tl_d2h_t     tl_i;

    always #5 clk_i = ~clk_i;

    mem_copy_host #(.LenWidth(16), .SourceId(SRC_ID)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .src_addr_i  (src_addr_i),
        .dst_addr_i  (dst_addr_i),
        .len_words_i (len_words_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .tl_o        (tl_o),
        .tl_i        (tl_i)
    );

    typedef struct {
        bit          is_put;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    op_t         sb_q[$];
    logic [31:0] mem [logic [31:0]];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Code bit j collects payload bits 63-j, 63-j-7, ...
    function automatic logic [6:0] fold7(input logic [63:0] v);
        logic [6:0] r;
        for (int j = 0; j < 7; j++) begin
            r[j] = 1'b0;
            for (int i = 63 - j; i >= 0; i -= 7) r[j] = r[j] ^ v[i];
        end
        return r;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                            input int stall_get, input int stall_cyc, input int err_put,
                            input int restart_at, input int exp_done, input logic [3:0] rd_tag);
        logic [31:0] sa, da, rsp_data, exp_data;
        logic [2:0]  exp_opc;
        logic [3:0]  exp_cap;
        logic        rsp_err, exp_err;
        bit          hs_prev, held_ok;
        tl_h2d_t     held;
        op_t         op;
        int          gets, puts, done_cnt, done_cyc, busy_cnt, stall_left;

        sa = {s[31:2], 2'b00};
        da = {d[31:2], 2'b00};
        gets = 0; puts = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0;
        stall_left = stall_cyc; hs_prev = 0; held_ok = 0;
        rsp_data = '0; rsp_err = 1'b0;
        for (int i = 0; i < n; i++) mem[sa + 32'(4 * i)] = $urandom;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('{is_put: 1'b0, addr: sa + 32'(4 * i), data: 32'h0});
            sb_q.push_back('{is_put: 1'b1, addr: da + 32'(4 * i), data: mem[sa + 32'(4 * i)]});
            if (i == err_put) break;
        end
        exp_err = (err_put >= 0) && (err_put < n);

        @(negedge clk_i);
        start_i     = 1'b1;
        src_addr_i  = s;
        dst_addr_i  = d;
        len_words_i = 16'(n);

        for (int k = 1; k <= 300; k++) begin
            @(negedge clk_i);
            start_i = (k == restart_at);
            if (k == restart_at) src_addr_i = 32'h0BAD_0000;
            if (busy_o) busy_cnt++;
            if (done_o) begin
                done_cnt++;
                done_cyc = k;
            end
            tl_i.d_valid        = hs_prev;
            tl_i.d_data         = rsp_data;
            tl_i.d_error        = rsp_err & hs_prev;
            tl_i.d_user.cap_tag = rd_tag;
            hs_prev             = 0;
            tl_i.a_ready        = 1'b1;
            if (tl_o.a_valid) begin
                if (tl_o.a_opcode == Get && gets == stall_get && stall_left > 0) begin
                    tl_i.a_ready = 1'b0;
                    stall_left--;
                    if (!held_ok) begin
                        held    = tl_o;
                        held_ok = 1;
                    end else chk("a_stable", 128'(tl_o), 128'(held));
                end else begin
                    if (held_ok) begin
                        chk("a_stable_hs", 128'(tl_o), 128'(held));
                        held_ok = 0;
                    end
                    chk("req_expected", 128'(sb_q.size() > 0), 128'(1));
                    $display("txn op=%0d addr=%08h data=%08h user=%05h", tl_o.a_opcode,
                             tl_o.a_address, tl_o.a_data, tl_o.a_user);
                    if (sb_q.size() > 0) begin
                        op       = sb_q.pop_front();
                        exp_opc  = op.is_put ? 3'(PutFullData) : 3'(Get);
                        exp_data = op.is_put ? op.data : 32'h0;
                        chk("a_op_addr", 128'({tl_o.a_opcode, tl_o.a_address}), 128'({exp_opc, op.addr}));
                        chk("a_data", 128'(tl_o.a_data), 128'(exp_data));
                    end
                    chk("a_attr", 128'({tl_o.a_param, tl_o.a_size, tl_o.a_mask, tl_o.a_source}),
                        128'({3'd0, 2'd2, 4'hF, 8'(SRC_ID)}));
                    chk("cmd_intg", 128'(tl_o.a_user.cmd_intg),
                        128'(fold7({23'd0, tl_o.a_opcode, tl_o.a_size, tl_o.a_mask, tl_o.a_address})));
                    chk("data_intg", 128'(tl_o.a_user.data_intg), 128'(fold7({32'd0, tl_o.a_data})));
                    if (tl_o.a_opcode == Get) begin
                        chk("get_cap", 128'(tl_o.a_user.cap_tag), 128'(4'd0));
                        rsp_data         = mem_rd(tl_o.a_address);
                        rsp_err          = 1'b0;
                        tl_i.d_opcode    = AccessAckData;
                        gets++;
                    end else begin
`ifdef MEM_COPY_HOST_CAP_EN
                        exp_cap = rd_tag;
`else
                        exp_cap = 4'd0;
`endif
                        chk("put_cap", 128'(tl_o.a_user.cap_tag), 128'(exp_cap));
                        mem[tl_o.a_address] = tl_o.a_data;
                        rsp_data         = 32'h0;
                        rsp_err          = (puts == err_put);
                        tl_i.d_opcode    = AccessAck;
                        puts++;
                    end
                    hs_prev = 1;
                end
            end
            if (done_o) break;
        end

        chk("done_count", 128'(done_cnt), 128'(1));
        chk("err", 128'(err_o), 128'(exp_err));
        chk("sb_empty", 128'(sb_q.size()), 128'(0));
        chk("busy_cycles", 128'(busy_cnt), 128'(done_cyc));
        if (exp_done >= 0) chk("done_cycle", 128'(done_cyc), 128'(exp_done));
        @(negedge clk_i);
        tl_i.d_valid = 1'b0;
        tl_i.d_error = 1'b0;
        chk("post_idle", 128'({busy_o, done_o, tl_o.a_valid}), 128'(3'b000));
        $display("copy src=%08h dst=%08h len=%0d done_at=%0d err=%0b", s, d, n, done_cyc, err_o);
        sb_q.delete();
    endtask

    initial begin
        rst_ni       = 1'b0;
        start_i      = 1'b0;
        src_addr_i   = '0;
        dst_addr_i   = '0;
        len_words_i  = '0;
        tl_i         = '0;
        tl_i.a_ready = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("reset_state", 128'({busy_o, done_o, err_o, tl_o.a_valid, tl_o.d_ready}), 128'(5'b00001));
        rst_ni = 1'b1;

        // Basic 4-word copy, zero-wait device; a start mid-copy must be ignored.
        run_copy(32'h100, 32'h200, 4, -1, 0, -1, 6, 17, 4'd1);
        // Zero length: no traffic, done one cycle after start.
        run_copy(32'h400, 32'h500, 0, -1, 0, -1, -1, 1, 4'd1);
        // Misaligned addresses, second Get held off for 5 cycles.
        run_copy(32'h301, 32'h603, 3, 1, 5, -1, -1, 18, 4'd1);
        // Error on second write ends the copy before a third Get.
        run_copy(32'h700, 32'h800, 3, -1, 0, 1, -1, 9, 4'd2);
        // Source address wraps through zero; err clears on this start.
        run_copy(32'hFFFF_FFFC, 32'h900, 2, -1, 0, -1, -1, 9, 4'd1);

        // Reset mid-copy, then a stray late response must be discarded.
        @(negedge clk_i);
        start_i     = 1'b1;
        src_addr_i  = 32'hA00;
        dst_addr_i  = 32'hB00;
        len_words_i = 16'd4;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("mid_reset", 128'({busy_o, done_o, err_o, tl_o.a_valid}), 128'(4'b0000));
        @(negedge clk_i);
        rst_ni       = 1'b1;
        tl_i.d_valid = 1'b1;
        tl_i.d_error = 1'b1;
        @(negedge clk_i);
        tl_i.d_valid = 1'b0;
        tl_i.d_error = 1'b0;
        chk("stray_rsp", 128'({busy_o, err_o, tl_o.a_valid}), 128'(3'b000));

        // Recovery after reset, distinct capability tag.
        run_copy(32'hC00, 32'hD00, 2, -1, 0, -1, -1, 9, 4'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
